mac_tx_sched: RTL
=================

# mac_tx_sched

Transmit scheduler that shares the single `mac_tx` RMII transmitter among several 16-bit word requesters, such as logic-analyzer read responses and status words.
- Each requester gets a one-deep holding register.
- A round-robin arbiter picks the next word and issues a one-cycle `start` pulse to `mac_tx`.
- The block watches `txen` to track frame completion, then enforces the Ethernet interframe gap before the next grant.
- It sits between the bus/response logic and `mac_tx`, on the 50 MHz `ethclk` domain.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, range 2..8.
- `IFG_CYCLES`, default 48: idle cycles after `txen` falls, before the next start. 96 bit-times at 2 bits/cycle.
- `START_TIMEOUT`, default 16: maximum cycles to wait for `txen` to rise after `start`.

Ports:
- `clk` in 1: `ethclk`, 50 MHz; all logic on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: bit i means requester i offers a word.
- `req_data` in 16*N_REQ: word for requester i in bits [16i+15:16i].
- `req_ready` out N_REQ: bit i means holding register i is empty. Transfer occurs when `req_valid[i] & req_ready[i]`.
- `mac_data` out 16: word presented to `mac_tx.data`.
- `mac_start` out 1: one-cycle start pulse to `mac_tx`.
- `mac_txen` in 1: `mac_tx.txen`, observed.
- `busy` out 1: high in any state other than IDLE.
- `grant_id` out clog2(N_REQ): requester whose word is in flight.
- `frames_sent` out 16: count of frames for which `txen` was seen to rise and fall.
- `timeouts` out 8: count of `start` pulses with no `txen` response.

## Operation
- Holding registers `hold[i]` and `pending[i]`.
  - `req_ready[i] = !pending[i]`.
  - An accepted transfer loads `hold[i]` and sets `pending[i]`.
- FSM states: IDLE, START, WAIT_TX, BUSY, IFG.
- IDLE:
  - If any `pending` bit is set, select the first set bit searching from `last_grant+1` upward, wrapping modulo N_REQ.
  - On selection: load `mac_data <= hold[sel]`, set `grant_id <= sel` and `last_grant <= sel`, clear `pending[sel]`, and go to START.
- START:
  - `mac_start = 1` for exactly this cycle; unconditionally go to WAIT_TX.
  - Clear the wait counter.
- WAIT_TX:
  - `mac_txen = 1` → BUSY.
  - Otherwise increment the wait counter. When the counter reaches START_TIMEOUT, increment `timeouts` and go to IFG.
- BUSY: remain while `mac_txen = 1`. On `mac_txen = 0`, increment `frames_sent` and go to IFG.
- IFG: count IFG_CYCLES cycles, then go to IDLE.
- `mac_data` and `grant_id` hold from the IDLE→START transition until the next grant.
- Counter width rules:
  - `frames_sent` wraps from 0xFFFF to 0.
  - `timeouts` saturates at 0xFF.
- Boundary conditions:
  - A requester whose pending bit clears at grant shows `req_ready` high the following cycle, so it can refill during the frame.
  - An accept and a grant never target the same requester in one cycle, because ready is low while pending.
  - All requesters idle: remain in IDLE with `busy = 0`.
  - `mac_txen` high while in IDLE or IFG is ignored and does not restart the FSM.

## Timing
- Reset values (asynchronous on `rstn` low):
  - FSM = IDLE.
  - `mac_start = 0`, `mac_data = 0`, `grant_id = 0`.
  - `last_grant = N_REQ-1`, so the first grant searches from 0.
  - `pending = 0`, so `req_ready` is all ones.
  - Counters = 0, `busy = 0`.
- Reset asserted mid-frame drops `mac_start` immediately and discards all held words. Release is synchronous to `clk` through the existing reset synchronizer.
- All outputs are registered except `req_ready`, which is decoded from a register with no dependence on inputs.
- Latency:
  - Accept at edge k → `pending` set after k.
  - IDLE grant at edge k+1.
  - `mac_start` high during cycle k+1 to k+2.
  - Minimum accept-to-start latency is 1 cycle after pending is visible.
- Spacing: minimum cycles from a `txen` fall to the next `mac_start` rise = IFG_CYCLES + 2.

## Test plan
- Single request: requester 0 offers 0x5678.
  - `mac_start` pulses once with `mac_data = 0x5678`, `grant_id = 0`.
  - A `mac_tx` model raises `txen` for 100 cycles; `frames_sent = 1` after the fall and `busy` returns to 0 after 48 IFG cycles.
- Round-robin: requesters 0..3 offer 0x1111, 0x2222, 0x3333, 0x4444 in the same cycle.
  - Starts occur in order 0, 1, 2, 3.
  - A second burst with only 1 and 3 pending is served 1 then 3.
- IFG and refill: requester 2 offers back-to-back words 0xAAAA and 0xBBBB.
  - `req_ready[2]` returns high the cycle after the first grant.
  - The second `mac_start` rises exactly 50 cycles after the first `txen` fall.
- Timeout: model holds `txen = 0`.
  - `timeouts` increments to 1 after 16 WAIT_TX cycles and `frames_sent` stays 0.
  - The next pending word starts after IFG.
  - Repeated 300 times, `timeouts` saturates at 255.
- Reset mid-frame: assert `rstn = 0` while in BUSY with two words pending.
  - `mac_start`, `busy` and `pending` go to 0 immediately and `req_ready` is all ones.
  - After release, a new request is granted to requester 0.
- Stray `txen`: pulse `mac_txen` for 10 cycles while in IDLE with nothing pending; FSM stays IDLE and `frames_sent` is unchanged.

Source files
------------

// File: rtl/mac_tx_sched.sv
// Round-robin transmit scheduler feeding one mac_tx instance: one-deep holding
// register per requester, one-cycle start pulse, txen tracking and interframe gap.
`timescale 1ns/1ps
module mac_tx_sched #(
  parameter int N_REQ         = 4,
  parameter int IFG_CYCLES    = 48,
  parameter int START_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [16*N_REQ-1:0]      req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic [15:0]              mac_data,
  output logic                     mac_start,
  input  logic                     mac_txen,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic [15:0]              frames_sent,
  output logic [7:0]               timeouts
);
  localparam int          GW        = $clog2(N_REQ);
  localparam logic [15:0] WAIT_LAST = 16'(START_TIMEOUT - 1);
  localparam logic [15:0] IFG_LAST  = 16'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_TX,
    S_BUSY,
    S_IFG
  } state_t;

  state_t           state, state_nx;
  logic [N_REQ-1:0] pending, accept, grant_mask;
  logic [15:0]      hold [N_REQ];
  logic [GW-1:0]    last_grant, sel;
  logic             sel_found;
  logic [15:0]      wait_cnt, ifg_cnt;
  logic             grant_fire, tx_done, timeout_fire;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign req_ready = ~pending;
  assign accept    = req_valid & ~pending;

  // Holding words carry no reset; pending alone says whether a word is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) hold[i] <= req_data[16*i +: 16];
    end
  end

  always_comb begin
    int idx;
    idx       = 0;
    sel       = '0;
    sel_found = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(last_grant) + off) % N_REQ;
      if (!sel_found && pending[idx]) begin
        sel_found = 1'b1;
        sel       = GW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (sel_found) state_nx = S_START;
      S_START:   state_nx = S_WAIT_TX;
      S_WAIT_TX: begin
        if (mac_txen)                   state_nx = S_BUSY;
        else if (wait_cnt == WAIT_LAST) state_nx = S_IFG;
      end
      S_BUSY:    if (!mac_txen) state_nx = S_IFG;
      S_IFG:     if (ifg_cnt == IFG_LAST) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    grant_fire   = (state == S_IDLE) && sel_found;
    tx_done      = (state == S_BUSY) && !mac_txen;
    timeout_fire = (state == S_WAIT_TX) && !mac_txen && (wait_cnt == WAIT_LAST);
    grant_mask   = '0;
    if (grant_fire) grant_mask[sel] = 1'b1;
  end

  // Registered outputs are loaded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending     <= '0;
      last_grant  <= GW'(N_REQ - 1);
      mac_data    <= '0;
      grant_id    <= '0;
      mac_start   <= 1'b0;
      busy        <= 1'b0;
      frames_sent <= '0;
      timeouts    <= '0;
      wait_cnt    <= '0;
      ifg_cnt     <= '0;
    end else begin
      pending   <= (pending | accept) & ~grant_mask;
      mac_start <= (state_nx == S_START);
      busy      <= (state_nx != S_IDLE);
      wait_cnt  <= (state == S_WAIT_TX) ? wait_cnt + 16'd1 : 16'd0;
      ifg_cnt   <= (state == S_IFG) ? ifg_cnt + 16'd1 : 16'd0;
      if (grant_fire) begin
        mac_data   <= hold[sel];
        grant_id   <= sel;
        last_grant <= sel;
      end
      if (tx_done)      frames_sent <= frames_sent + 16'd1;
      if (timeout_fire) timeouts    <= sat_inc8(timeouts);
    end
  end

endmodule
